dsi_pkt_lane_builder: RTL and testbench
=======================================

Name: dsi_pkt_lane_builder

Overview:
Builds MIPI DSI short and long packets and distributes them byte-wise across 4 data lanes. It produces the hs_en burst window and the byte_D3..D0 streams that feed the LP/HS delay controller directly downstream. Header ECC and payload CRC-16 are generated in-line. Between packets it enforces a minimum hs_en-low gap so the downstream end-of-burst sequence can complete.

Parameters:
GAP_CYCLES, 24, minimum byte_clk cycles hs_en stays low after a burst; must be at least the downstream end-sequence length.
WC_W, 16, word-count width; fixed by DSI.

Ports:
byte_clk  in  1  byte clock
reset_n  in  1  asynchronous, active-low reset
pkt_req  in  1  packet request; hold until pkt_ack
pkt_di  in  8  data identifier (VC[7:6], DT[5:0])
pkt_wc  in  16  long: payload byte count; short: {data1, data0}
pkt_long  in  1  1 = long packet, 0 = short packet
pkt_ack  out  1  1-cycle pulse: request accepted and fields latched
pl_data  in  32  payload word; byte k on bits [8k+7:8k], k=0 sent first
pl_valid  in  1  payload word valid
pl_ready  out  1  payload word consumed this cycle
hs_en  out  1  HS burst window to the delay controller
byte_D3_out / byte_D2_out / byte_D1_out / byte_D0_out  out  8 each  lane bytes
busy  out  1  not in IDLE
underrun  out  1  sticky; set when payload is required and pl_valid=0

Behaviour:
- Reset values: hs_en=0, all lane bytes=0x00, pkt_ack=0, pl_ready=0, busy=0, underrun=0, state=IDLE, gap counter=0.
- FSM states: IDLE, HDR, PAYLOAD, TAIL, GAP.
- IDLE & pkt_req: latch di/wc/long, pulse pkt_ack, go to HDR. This is a 1-cycle decision.
- Output stage is registered. Lane bytes and hs_en change on the edge after the state decision.
- HDR cycle outputs: hs_en=1; D0=DI, D1=WC[7:0], D2=WC[15:8], D3=ECC.
- ECC: standard DSI 6-bit Hamming over the 24-bit header; bits[7:6]=0.
- Short packet: HDR → GAP. The burst is exactly 1 cycle of hs_en.
- Long packet: HDR → PAYLOAD when wc>0, or HDR → TAIL when wc=0.
- Byte n of the payload+CRC stream goes to lane n mod 4.
- PAYLOAD:
  - pl_ready=1 for ceil(wc/4) cycles, one word per cycle.
  - Only the first (wc mod 4, or 4) bytes of the last word are used.
  - CRC-16: poly x^16+x^12+x^5+1, reflected (0x8408), init 0xFFFF, LSB-first, no final XOR.
  - Computed 4-byte parallel, with a byte-masked update on the last word.
- CRC placement after the final payload word, by r = wc mod 4:
  - r=1: CRC lo/hi on lanes 1/2 of the last payload cycle; lane 3 = 0x00; → GAP.
  - r=2: CRC lo/hi on lanes 2/3; → GAP.
  - r=3: CRC lo on lane 3; → TAIL, lane 0 = CRC hi.
  - r=0: → TAIL, lanes 0/1 = CRC lo/hi.
- TAIL: one cycle, hs_en=1. Unused lanes = 0x00, including all lanes 2-3 padding.
- Underrun:
  - PAYLOAD with pl_valid=0: transmit 0x00 for the needed bytes and set underrun.
  - The word counter still advances; hs_en never stalls mid-burst.
  - CRC is computed over the transmitted bytes.
- GAP:
  - hs_en=0 and lanes=0x00.
  - Counts GAP_CYCLES, then → IDLE.
  - pkt_req is ignored (no ack) until IDLE.
- wc=0xFFFF: 16384 payload cycles, r=3. The counter must not overflow.
- underrun clears only on reset.
- Reset mid-burst: immediate return to reset values. No gap is enforced after reset because the downstream block also resets.

Decomposition:
- Shared package dsi_pkg:
  - DT constants (0x05 DCS short no-param, 0x15 DCS short 1-param, 0x39 DCS long write).
  - State encoding.
  - ECC function.
  - CRC-16 byte-update function.
- One natural sub-module: dsi_crc16_x4. It takes a 4-byte parallel CRC, a byte-enable mask and a clear input, and is reused by a future receive checker.

Test Plan:
- Short packet, DI=0x05, wc=0x0029 → 1-cycle hs_en, lanes D0..D3 = 05, 29, 00, 1C; then ≥24 cycles with hs_en=0.
- Long packet, DI=0x39, wc=0 → HDR lanes 39, 00, 00, 0F; next cycle lanes FF, FF, 00, 00; hs_en high exactly 2 cycles.
- Long packets with wc=4, 5, 6, 7 and random payload:
  - hs_en high for 3, 3, 3, 4 cycles respectively.
  - CRC bytes land on the lanes given by r.
  - CRC matches the bench model.
- Back-to-back pkt_req held high → second pkt_ack only after GAP_CYCLES of hs_en low; no overlap.
- pl_valid dropped for one payload cycle at wc=8 → lanes 0x00 that cycle, underrun=1, burst length unchanged.
- reset_n asserted during PAYLOAD → hs_en=0, lanes=0, busy=0 immediately; a fresh request after release is accepted.

Source files
------------

// File: rtl/dsi_pkg.sv
// Shared DSI definitions for the packet lane builder and its CRC helper.
// Holds data-type constants, the builder state encoding, the lane-byte payload
// struct, the header ECC function and the CRC-16 byte-update function.
package dsi_pkg;

    localparam int unsigned WC_W   = 16;
    // Payload word counter holds ceil(wc/4)-1, which fits in WC_W-2 bits even for wc=0xFFFF.
    localparam int unsigned WCNT_W = WC_W - 2;

    localparam logic [5:0] DT_DCS_SHORT_NP = 6'h05;
    localparam logic [5:0] DT_DCS_SHORT_1P = 6'h15;
    localparam logic [5:0] DT_DCS_LONG_WR  = 6'h39;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_TAIL    = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    // One byte per data lane; d0 carries the earliest byte of each group of four.
    typedef struct packed {
        logic [7:0] d3;
        logic [7:0] d2;
        logic [7:0] d1;
        logic [7:0] d0;
    } lanes_t;

    // Header bits covered by each ECC parity bit (index 0 = P0).
    localparam logic [5:0][23:0] ECC_MASKS = {
        24'hEFFC00, 24'hDF03F0, 24'hB8E38E,
        24'h749A6D, 24'hF2555B, 24'hF12CB7
    };

    // DSI header ECC over {WC[15:8], WC[7:0], DI}; top two bits are always zero.
    function automatic logic [7:0] dsi_ecc(input logic [23:0] hdr);
        logic [7:0] ecc;
        ecc = 8'h00;
        for (int unsigned i = 0; i < 6; i++) begin
            ecc[i] = ^(hdr & ECC_MASKS[i]);
        end
        return ecc;
    endfunction

    // Reflected CRC-16 (poly 0x8408) advanced by one byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            c = (c[0] ^ b[i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/dsi_crc16_x4.sv
// Four-byte parallel DSI payload CRC-16 accumulator.
// Ports: byte_clk/reset_n clock and async reset; clear reloads 0xFFFF (wins over en);
// en folds in the bytes of data selected by be (contiguous from byte 0);
// crc is the registered running value; crc_next_c is the value including this cycle's bytes.
module dsi_crc16_x4
    import dsi_pkg::*;
(
    input  logic        byte_clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        en,
    input  logic [31:0] data,
    input  logic [3:0]  be,
    output logic [15:0] crc,
    output logic [15:0] crc_next_c
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Byte 0 is folded in first, matching lane order on the wire.
    always_comb begin
        logic [15:0] c;
        c = crc_q;
        for (int unsigned k = 0; k < 4; k++) begin
            if (be[k]) begin
                c = crc16_byte(c, data[8*k +: 8]);
            end
        end
        crc_next_c = c;
    end

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = 16'hFFFF;
        end else if (en) begin
            crc_d = crc_next_c;
        end
    end

    always_ff @(posedge byte_clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= 16'hFFFF;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/dsi_pkt_lane_builder.sv
// DSI short/long packet builder distributing bytes over four HS data lanes.
// Ports: pkt_req/pkt_di/pkt_wc/pkt_long request a packet, pkt_ack pulses on acceptance;
// pl_data/pl_valid supply payload words, pl_ready marks a word consumed;
// hs_en and byte_D3..D0_out feed the LP/HS delay controller; busy is high outside IDLE;
// underrun is sticky once a payload word was missing when needed.
module dsi_pkt_lane_builder
    import dsi_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 24
) (
    input  logic        byte_clk,
    input  logic        reset_n,
    input  logic        pkt_req,
    input  logic [7:0]  pkt_di,
    input  logic [15:0] pkt_wc,
    input  logic        pkt_long,
    output logic        pkt_ack,
    input  logic [31:0] pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic        hs_en,
    output logic [7:0]  byte_D3_out,
    output logic [7:0]  byte_D2_out,
    output logic [7:0]  byte_D1_out,
    output logic [7:0]  byte_D0_out,
    output logic        busy,
    output logic        underrun
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    state_t              state_q, state_d;
    logic [7:0]          di_q, di_d;
    logic [WC_W-1:0]     wc_q, wc_d;
    logic                long_q, long_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                hs_en_q, hs_en_d;
    lanes_t              lanes_q, lanes_d;
    logic                pkt_ack_q, pkt_ack_d;
    logic                pl_ready_q, pl_ready_d;
    logic                busy_q, busy_d;
    logic                underrun_q, underrun_d;

    logic                crc_clr;
    logic                crc_en;
    logic [3:0]          crc_be;
    logic [31:0]         crc_data;
    logic [15:0]         crc_cur;
    logic [15:0]         crc_next;

    logic [1:0]          rem;
    logic                last_word;
    logic [31:0]         byte_mask;

    assign rem       = wc_q[1:0];
    assign last_word = (word_cnt_q == '0);

    dsi_crc16_x4 u_crc (
        .byte_clk   (byte_clk),
        .reset_n    (reset_n),
        .clear      (crc_clr),
        .en         (crc_en),
        .data       (crc_data),
        .be         (crc_be),
        .crc        (crc_cur),
        .crc_next_c (crc_next)
    );

    // Next-state and registered-output decisions.
    always_comb begin
        state_d    = state_q;
        di_d       = di_q;
        wc_d       = wc_q;
        long_d     = long_q;
        word_cnt_d = word_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        hs_en_d    = 1'b0;
        lanes_d    = '0;
        pkt_ack_d  = 1'b0;
        underrun_d = underrun_q;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        crc_be     = 4'hF;
        crc_data   = '0;
        byte_mask  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (pkt_req) begin
                    di_d      = pkt_di;
                    wc_d      = pkt_wc;
                    long_d    = pkt_long;
                    pkt_ack_d = 1'b1;
                    crc_clr   = 1'b1;
                    state_d   = ST_HDR;
                end
            end

            ST_HDR: begin
                hs_en_d = 1'b1;
                lanes_d = lanes_t'({dsi_ecc({wc_q, di_q}), wc_q, di_q});
                if (!long_q) begin
                    state_d = ST_GAP;
                end else if (wc_q == '0) begin
                    state_d = ST_TAIL;
                end else begin
                    word_cnt_d = WCNT_W'((wc_q - WC_W'(1)) >> 2);
                    state_d    = ST_PAYLOAD;
                end
            end

            ST_PAYLOAD: begin
                hs_en_d  = 1'b1;
                crc_en   = 1'b1;
                // Missing word: send zeros and keep going so the burst never stalls.
                crc_data = pl_valid ? pl_data : 32'h0;
                if (!pl_valid) begin
                    underrun_d = 1'b1;
                end
                if (last_word) begin
                    unique case (rem)
                        2'd1:    crc_be = 4'b0001;
                        2'd2:    crc_be = 4'b0011;
                        2'd3:    crc_be = 4'b0111;
                        default: crc_be = 4'b1111;
                    endcase
                end
                byte_mask = {{8{crc_be[3]}}, {8{crc_be[2]}}, {8{crc_be[1]}}, {8{crc_be[0]}}};
                lanes_d   = lanes_t'(crc_data & byte_mask);
                if (last_word) begin
                    // CRC fills the lanes right after the last payload byte.
                    unique case (rem)
                        2'd1: begin
                            lanes_d.d1 = crc_next[7:0];
                            lanes_d.d2 = crc_next[15:8];
                            state_d    = ST_GAP;
                        end
                        2'd2: begin
                            lanes_d.d2 = crc_next[7:0];
                            lanes_d.d3 = crc_next[15:8];
                            state_d    = ST_GAP;
                        end
                        2'd3: begin
                            lanes_d.d3 = crc_next[7:0];
                            state_d    = ST_TAIL;
                        end
                        default: begin
                            state_d = ST_TAIL;
                        end
                    endcase
                end else begin
                    word_cnt_d = word_cnt_q - WCNT_W'(1);
                end
            end

            ST_TAIL: begin
                hs_en_d = 1'b1;
                if (rem == 2'd3) begin
                    lanes_d.d0 = crc_cur[15:8];
                end else begin
                    lanes_d.d0 = crc_cur[7:0];
                    lanes_d.d1 = crc_cur[15:8];
                end
                state_d = ST_GAP;
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pl_ready_d = (state_d == ST_PAYLOAD);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge byte_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            di_q       <= '0;
            wc_q       <= '0;
            long_q     <= 1'b0;
            word_cnt_q <= '0;
            gap_cnt_q  <= '0;
            hs_en_q    <= 1'b0;
            lanes_q    <= '0;
            pkt_ack_q  <= 1'b0;
            pl_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            di_q       <= di_d;
            wc_q       <= wc_d;
            long_q     <= long_d;
            word_cnt_q <= word_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            hs_en_q    <= hs_en_d;
            lanes_q    <= lanes_d;
            pkt_ack_q  <= pkt_ack_d;
            pl_ready_q <= pl_ready_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
        end
    end

    assign pkt_ack     = pkt_ack_q;
    assign pl_ready    = pl_ready_q;
    assign hs_en       = hs_en_q;
    assign byte_D3_out = lanes_q.d3;
    assign byte_D2_out = lanes_q.d2;
    assign byte_D1_out = lanes_q.d1;
    assign byte_D0_out = lanes_q.d0;
    assign busy        = busy_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_dsi_pkt_lane_builder.sv
// Self-checking bench for dsi_pkt_lane_builder: a byte-stream model of each packet
// is queued on acceptance and one negedge monitor compares every lane cycle to it.
module tb_dsi_pkt_lane_builder;

    localparam int unsigned GAP = 24;

    logic        byte_clk = 1'b0;
    logic        reset_n;
    logic        pkt_req;
    logic [7:0]  pkt_di;
    logic [15:0] pkt_wc;
    logic        pkt_long;
    logic        pkt_ack;
    logic [31:0] pl_data = 32'h0;
    logic        pl_valid = 1'b0;
    logic        pl_ready;
    logic        hs_en;
    logic [7:0]  d3, d2, d1, d0;
    logic        busy;
    logic        underrun;

    always #5 byte_clk = ~byte_clk;

    dsi_pkt_lane_builder #(.GAP_CYCLES(GAP)) dut (
        .byte_clk    (byte_clk),
        .reset_n     (reset_n),
        .pkt_req     (pkt_req),
        .pkt_di      (pkt_di),
        .pkt_wc      (pkt_wc),
        .pkt_long    (pkt_long),
        .pkt_ack     (pkt_ack),
        .pl_data     (pl_data),
        .pl_valid    (pl_valid),
        .pl_ready    (pl_ready),
        .hs_en       (hs_en),
        .byte_D3_out (d3),
        .byte_D2_out (d2),
        .byte_D1_out (d1),
        .byte_D0_out (d0),
        .busy        (busy),
        .underrun    (underrun)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    localparam logic [23:0] ECC_M [6] = '{24'hF12CB7, 24'hF2555B, 24'h749A6D,
                                          24'hB8E38E, 24'hDF03F0, 24'hEFFC00};

    function automatic logic [7:0] m_ecc(input logic [23:0] h);
        logic [7:0] e;
        e = 8'h00;
        for (int p = 0; p < 6; p++)
            for (int b = 0; b < 24; b++)
                if (ECC_M[p][b]) e[p] = e[p] ^ h[b];
        return e;
    endfunction

    function automatic logic [15:0] m_crc(input logic [7:0] s [$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (s[i])
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ s[i][j];
                c  = c >> 1;
                if (fb) c = c ^ 16'h8408;
            end
        return c;
    endfunction

    logic [31:0] words [16384];
    logic [32:0] stage_q [$];   // {underrun_cycle, D3,D2,D1,D0} per hs_en cycle
    int          stage_rdy;
    logic [32:0] exp_q [$];
    int          len_q [$];
    int          rdy_q [$];

    // Whole packet as it must appear on the lanes: header cycle, then payload+CRC bytes round-robin.
    function automatic void build(input logic [7:0] di, input logic [15:0] wc, input bit lng, input int drop);
        logic [7:0]  s [$];
        logic [15:0] c;
        int          nw;
        stage_q.delete();
        stage_q.push_back({1'b0, m_ecc({wc, di}), wc[15:8], wc[7:0], di});
        stage_rdy = 0;
        if (!lng) return;
        nw = (int'(wc) + 3) / 4;
        stage_rdy = nw;
        for (int n = 0; n < int'(wc); n++)
            s.push_back((n / 4 == drop) ? 8'h00 : words[n / 4][8 * (n % 4) +: 8]);
        c = m_crc(s);
        s.push_back(c[7:0]);
        s.push_back(c[15:8]);
        while (s.size() % 4 != 0) s.push_back(8'h00);
        for (int i = 0; i < s.size() / 4; i++)
            stage_q.push_back({(i == drop) && (i < nw), s[4*i+3], s[4*i+2], s[4*i+1], s[4*i]});
    endfunction

    // ---------------- payload source ----------------
    int widx = 0;
    int drop_idx = -1;

    always @(negedge byte_clk) begin
        if (!reset_n) begin
            pl_valid = 1'b0;
            widx     = 0;
        end else begin
            if (pkt_ack) widx = 0;
            if (pl_ready) begin
                pl_data  = words[widx % 16384];
                pl_valid = (widx != drop_idx);
                widx++;
            end else begin
                pl_valid = 1'b0;
                pl_data  = $urandom;
            end
        end
    end

    // ---------------- compare process ----------------
    logic [31:0] lanes;
    logic [32:0] e;
    int          run = 0;
    int          low_run = 0;
    int          rdy_cnt = 0;
    bit          had_burst = 0;
    bit          prev_ack = 0;
    bit          exp_underrun = 0;

    always @(negedge byte_clk) begin
        lanes = {d3, d2, d1, d0};
        if (!reset_n) begin
            chk("rst_hs_en", 64'(hs_en), 64'd0);
            chk("rst_lanes", 64'(lanes), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_ack_ready", 64'({pkt_ack, pl_ready}), 64'd0);
            chk("rst_underrun", 64'(underrun), 64'd0);
            exp_q.delete(); len_q.delete(); rdy_q.delete();
            run = 0; low_run = 0; rdy_cnt = 0;
            had_burst = 0; prev_ack = 0; exp_underrun = 0;
        end else begin
            if (pkt_ack) begin
                chk("ack_pulse", 64'(prev_ack), 64'd0);
                if (had_burst) chk("gap_before_ack", 64'(low_run >= int'(GAP)), 64'd1);
                rdy_cnt = 0;
            end
            if (pl_ready) rdy_cnt++;
            if (hs_en) begin
                chk("burst_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (e[32]) exp_underrun = 1;
                    chk("lanes", 64'(lanes), 64'(e[31:0]));
                end
                chk("busy_in_burst", 64'(busy), 64'd1);
                run++;
                low_run = 0;
            end else begin
                if (run > 0) begin
                    chk("len_known", 64'(len_q.size() > 0 && rdy_q.size() > 0), 64'd1);
                    if (len_q.size() > 0) chk("burst_len", 64'(run), 64'(len_q.pop_front()));
                    if (rdy_q.size() > 0) chk("ready_cycles", 64'(rdy_cnt), 64'(rdy_q.pop_front()));
                    had_burst = 1;
                    run = 0;
                end
                chk("idle_lanes", 64'(lanes), 64'd0);
                low_run++;
            end
            chk("underrun", 64'(underrun), 64'(exp_underrun));
            prev_ack = pkt_ack;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] di, input logic [15:0] wc, input bit lng,
                        input int drop, input bit hold);
        int t;
        if (lng) for (int i = 0; i < (int'(wc) + 3) / 4; i++) words[i] = $urandom;
        drop_idx = drop;
        pkt_di   = di;
        pkt_wc   = wc;
        pkt_long = lng;
        pkt_req  = 1'b1;
        t = 0;
        do begin
            @(negedge byte_clk);
            t++;
        end while (!pkt_ack && t < 200);
        chk("ack_seen", 64'(pkt_ack), 64'd1);
        build(di, wc, lng, drop);
        foreach (stage_q[i]) exp_q.push_back(stage_q[i]);
        len_q.push_back(stage_q.size());
        rdy_q.push_back(stage_rdy);
        if (!hold) pkt_req = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge byte_clk);
            t++;
        end while (busy && t < 20000);
        chk("idle_reached", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [7:0] ascii [$];
        int t;
        reset_n  = 1'b0;
        pkt_req  = 1'b0;
        pkt_di   = 8'h00;
        pkt_wc   = 16'h0000;
        pkt_long = 1'b0;
        repeat (3) @(posedge byte_clk);
        #2 reset_n = 1'b1;

        // Model pins from hand-worked values.
        chk("pin_ecc_short", 64'(m_ecc(24'h002905)), 64'h1C);
        chk("pin_ecc_long0", 64'(m_ecc(24'h000039)), 64'h0F);
        ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("pin_crc_check", 64'(m_crc(ascii)), 64'h6F91);

        // Short packet.
        send(8'h05, 16'h0029, 1'b0, -1, 1'b0);
        chk("pin_short_words", 64'(stage_q.size()), 64'd1);
        chk("pin_short_hdr", 64'(stage_q[0]), 64'h0_1C002905);
        wait_idle();

        // Long packet with no payload.
        send(8'h39, 16'h0000, 1'b1, -1, 1'b0);
        chk("pin_wc0_words", 64'(stage_q.size()), 64'd2);
        chk("pin_wc0_hdr", 64'(stage_q[0]), 64'h0_0F000039);
        chk("pin_wc0_crc", 64'(stage_q[1]), 64'h0_0000FFFF);
        wait_idle();

        // wc = 4..7 cover every CRC placement.
        for (int w = 4; w <= 7; w++) begin
            send(8'h39, 16'(w), 1'b1, -1, 1'b0);
            chk("pin_wc_burst_len", 64'(stage_q.size()), 64'((w == 7) ? 4 : 3));
            wait_idle();
        end

        // Back-to-back requests with pkt_req held high.
        send(8'h15, 16'h12AB, 1'b0, -1, 1'b1);
        send(8'h05, 16'h0033, 1'b0, -1, 1'b0);
        wait_idle();

        // One missing payload word.
        send(8'h39, 16'd8, 1'b1, 1, 1'b0);
        chk("pin_underrun_len", 64'(stage_q.size()), 64'd4);
        wait_idle();

        // Random mix.
        for (int n = 0; n < 24; n++) begin
            logic [15:0] w;
            bit          lng;
            int          drop;
            lng  = ($urandom_range(0, 2) != 0);
            w    = lng ? 16'($urandom_range(0, 40)) : 16'($urandom);
            drop = (lng && w != 0 && $urandom_range(0, 4) == 0)
                   ? $urandom_range(0, (int'(w) + 3) / 4 - 1) : -1;
            send(8'($urandom), w, lng, drop, 1'b0);
            wait_idle();
        end

        // Maximum word count.
        send(8'h39, 16'hFFFF, 1'b1, -1, 1'b0);
        chk("pin_max_len", 64'(stage_q.size()), 64'd16386);
        wait_idle();

        // Reset in the middle of a payload burst.
        send(8'h39, 16'd40, 1'b1, -1, 1'b0);
        t = 0;
        while (!pl_ready && t < 50) begin
            @(negedge byte_clk);
            t++;
        end
        @(posedge byte_clk);
        @(posedge byte_clk);
        #2;
        chk("pre_rst_hs_en", 64'(hs_en), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_hs_en", 64'(hs_en), 64'd0);
        chk("mid_rst_lanes", 64'({d3, d2, d1, d0}), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(posedge byte_clk);
        @(posedge byte_clk);
        #2 reset_n = 1'b1;
        send(8'h39, 16'd10, 1'b1, -1, 1'b0);
        wait_idle();

        repeat (4) @(negedge byte_clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
